// File: rtl/ram_bist.sv
// ram_bist: BIST master for the dual-read-port RAM; writes P(a)=a^SEED over a window and reads it back two words per cycle.
// Define RAM_BIST_INV_PASS_EN to add a second pass with the inverted pattern ~P(a).
module ram_bist #(
    parameter int ADDR_W = 33,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED = DATA_W'(16'hA5A5)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_last,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] d_out_a,
    input  logic [DATA_W-1:0] d_out_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] fail_exp
);
    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE} state_t;

    state_t state, state_n;
    logic [ADDR_W-1:0] a, base, last, rd_a_q, rd_b_q, a_inc, a_inc2;
    logic [1:0] dcnt;
    logic pass_q, inv, rd_phase, at_last, pair_end, idle, ok_cfg;
    logic [DATA_W-1:0] exp_a, exp_b;
    logic chk_vld;
    logic [ADDR_W-1:0] chk_aa, chk_ab;
    logic [DATA_W-1:0] chk_ea, chk_eb;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] x, input logic n);
        return x[DATA_W-1:0] ^ SEED ^ {DATA_W{n}};
    endfunction

    localparam state_t TAIL = (RD_LAT == 0) ? DONE : DRAIN;
`ifdef RAM_BIST_INV_PASS_EN
    localparam state_t AFTER_RD0 = WR1;
    assign inv = (state == WR1) || (state == RD1);
`else
    localparam state_t AFTER_RD0 = TAIL;
    assign inv = 1'b0;
`endif

    assign idle      = (state == IDLE) || (state == DONE);
    assign ok_cfg    = cfg_last >= cfg_base;
    assign a_inc     = a + ADDR_W'(1);
    assign a_inc2    = a + ADDR_W'(2);
    // Equality tests run before any increment so the counter never wraps past the top address.
    assign at_last   = a == last;
    assign pair_end  = at_last || (a_inc == last);
    assign wr        = (state == WR0) || (state == WR1);
    assign rd_phase  = (state == RD0) || (state == RD1);
    assign wr_addr   = a;
    assign d_in      = wr ? pat(a, inv) : '0;
    assign rd_addr_a = rd_phase ? a : rd_a_q;
    assign rd_addr_b = rd_phase ? (at_last ? a : a_inc) : rd_b_q;
    assign exp_a     = pat(rd_addr_a, inv);
    assign exp_b     = pat(rd_addr_b, inv);
    assign busy      = !idle;
    assign done      = state == DONE;
    assign pass      = done & pass_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = ok_cfg ? WR0 : DONE;
            WR0:        if (at_last) state_n = RD0;
            RD0:        if (pair_end) state_n = AFTER_RD0;
            WR1:        if (at_last) state_n = RD1;
            RD1:        if (pair_end) state_n = TAIL;
            DRAIN:      if (dcnt == 2'(RD_LAT - 1)) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    // Read address/expected data travel with the RAM latency so they meet the returned words.
    generate
        if (RD_LAT == 0) begin : g_nolat
            assign chk_vld = rd_phase;
            assign chk_aa  = rd_addr_a;
            assign chk_ab  = rd_addr_b;
            assign chk_ea  = exp_a;
            assign chk_eb  = exp_b;
        end else begin : g_lat
            logic [RD_LAT-1:0] pv;
            logic [ADDR_W-1:0] paa [RD_LAT];
            logic [ADDR_W-1:0] pab [RD_LAT];
            logic [DATA_W-1:0] pea [RD_LAT];
            logic [DATA_W-1:0] peb [RD_LAT];
            always_ff @(posedge clk) begin
                if (reset) pv <= '0;
                else begin
                    pv[0] <= rd_phase;
                    for (int i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
                end
            end
            always_ff @(posedge clk) begin
                paa[0] <= rd_addr_a;
                pab[0] <= rd_addr_b;
                pea[0] <= exp_a;
                peb[0] <= exp_b;
                for (int i = 1; i < RD_LAT; i++) begin
                    paa[i] <= paa[i-1];
                    pab[i] <= pab[i-1];
                    pea[i] <= pea[i-1];
                    peb[i] <= peb[i-1];
                end
            end
            assign chk_vld = pv[RD_LAT-1];
            assign chk_aa  = paa[RD_LAT-1];
            assign chk_ab  = pab[RD_LAT-1];
            assign chk_ea  = pea[RD_LAT-1];
            assign chk_eb  = peb[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a         <= '0;
            base      <= '0;
            last      <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            dcnt      <= '0;
            pass_q    <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_exp  <= '0;
        end else begin
            state  <= state_n;
            rd_a_q <= rd_addr_a;
            rd_b_q <= rd_addr_b;
            dcnt   <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
            if (idle && start) begin
                base      <= cfg_base;
                last      <= cfg_last;
                a         <= cfg_base;
                pass_q    <= ok_cfg;
                fail_addr <= ok_cfg ? '0 : cfg_base;
                fail_data <= '0;
                fail_exp  <= '0;
            end else if (wr) a <= at_last ? base : a_inc;
            else if (rd_phase) a <= pair_end ? base : a_inc2;
            if (chk_vld && pass_q) begin
                if (d_out_a != chk_ea) begin
                    fail_addr <= chk_aa;
                    fail_data <= d_out_a;
                    fail_exp  <= chk_ea;
                    pass_q    <= 1'b0;
                end else if (d_out_b != chk_eb) begin
                    fail_addr <= chk_ab;
                    fail_data <= d_out_b;
                    fail_exp  <= chk_eb;
                    pass_q    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: drives ram_bist against a behavioural RAM with injectable stuck-at-1 bits.
// The expected cycle schedule and first-failure result are derived per window from plain arithmetic.
module tb_ram_bist;
    localparam int AW = 33;
    localparam int DW = 16;
    localparam int LAT = 1;
    localparam logic [DW-1:0] SD = 16'hA5A5;
    localparam logic [AW-1:0] MAXA = {AW{1'b1}};
`ifdef RAM_BIST_INV_PASS_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    logic clk = 0, reset = 1, start = 0;
    logic [AW-1:0] cfg_base = '0, cfg_last = '0;
    logic wr, busy, done, pass;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b, fail_addr;
    logic [DW-1:0] d_in, d_out_a = '0, d_out_b = '0, fail_data, fail_exp;
    int checks = 0, errors = 0, wr_cnt = 0;

    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] sa = '0;
    logic [DW-1:0] sm = '0;

    ram_bist #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .SEED(SD)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_last(cfg_last),
        .wr(wr), .wr_addr(wr_addr), .d_in(d_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .d_out_a(d_out_a), .d_out_b(d_out_b), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_exp(fail_exp)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rdm(input logic [AW-1:0] x);
        logic [DW-1:0] v;
        v = mem.exists(x) ? mem[x] : 16'h0;
        return (x == sa) ? (v | sm) : v;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] x, input int p);
        return x[DW-1:0] ^ SD ^ ((p != 0) ? 16'hFFFF : 16'h0000);
    endfunction

    // One-cycle-latency RAM: reads see contents before this edge's write.
    always @(posedge clk) begin
        d_out_a <= rdm(rd_addr_a);
        d_out_b <= rdm(rd_addr_b);
        if (wr) begin
            mem[wr_addr] = d_in;
            wr_cnt++;
        end
    end

    task automatic run_test(input logic [AW-1:0] b, input logic [AW-1:0] l, input bit poke, input string nm);
        int n, r, tot, cyc, p, k;
        logic [AW-1:0] x, ea, eb;
        logic [DW-1:0] e, g;
        bit pe;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd, fe;
        n = int'(l - b) + 1;
        r = (n + 1) / 2;
        tot = NP * (n + r) + LAT;
        pe = 1; fa = '0; fd = '0; fe = '0;
        for (int q = 0; q < NP; q++)
            for (int i = 0; i < n; i++) begin
                x = b + AW'(i);
                e = pat(x, q);
                g = (x == sa) ? (e | sm) : e;
                if (pe && g != e) begin
                    pe = 0; fa = x; fd = g; fe = e;
                end
            end
        @(negedge clk);
        cfg_base = b; cfg_last = l; start = 1;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (busy && cyc < tot + 10) begin
            if (cyc < NP * (n + r)) begin
                p = cyc / (n + r);
                k = cyc % (n + r);
                checks++;
                if (k < n) begin
                    x = b + AW'(k);
                    if ({wr, wr_addr, d_in} !== {1'b1, x, pat(x, p)}) begin
                        errors++;
                        $display("FAIL %s write cyc %0d: got wr=%b addr=%h d=%h want addr=%h d=%h",
                                 nm, cyc, wr, wr_addr, d_in, x, pat(x, p));
                    end
                end else begin
                    ea = b + AW'(2 * (k - n));
                    eb = (ea == l) ? ea : ea + AW'(1);
                    if ({wr, rd_addr_a, rd_addr_b} !== {1'b0, ea, eb}) begin
                        errors++;
                        $display("FAIL %s read cyc %0d: got wr=%b a=%h b=%h want a=%h b=%h",
                                 nm, cyc, wr, rd_addr_a, rd_addr_b, ea, eb);
                    end
                end
            end else begin
                checks++;
                if (wr !== 1'b0) begin
                    errors++;
                    $display("FAIL %s drain cyc %0d: got wr=%b want 0", nm, cyc, wr);
                end
            end
            if (poke && cyc == 3) begin
                start = 1; cfg_base = b + AW'(1); cfg_last = b;
            end
            @(negedge clk);
            start = 0;
            cyc++;
        end
        checks++;
        if (cyc != tot) begin
            errors++;
            $display("FAIL %s busy_len: got %0d want %0d", nm, cyc, tot);
        end
        checks++;
        if ({done, pass} !== {1'b1, pe}) begin
            errors++;
            $display("FAIL %s done/pass: got %b%b want 1%b", nm, done, pass, pe);
        end
        checks++;
        if ({fail_addr, fail_data, fail_exp} !== {fa, fd, fe}) begin
            errors++;
            $display("FAIL %s fail_regs: got %h/%h/%h want %h/%h/%h", nm, fail_addr, fail_data, fail_exp, fa, fd, fe);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, wr} !== 3'b100) begin
            errors++;
            $display("FAIL %s done_hold: got done=%b busy=%b wr=%b want 1 0 0", nm, done, busy, wr);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr, wr_addr, d_in, rd_addr_a, rd_addr_b, busy, done, pass, fail_addr, fail_data, fail_exp} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b wa=%h d=%h ra=%h rb=%h busy=%b done=%b pass=%b fa=%h want all 0",
                     wr, wr_addr, d_in, rd_addr_a, rd_addr_b, busy, done, pass, fail_addr);
        end
        reset = 0;
    endtask

    task automatic test_basic();
        sm = '0;
        run_test(33'd0, 33'd7, 0, "basic");
        checks++;
        if (mem[33'd7] !== ((NP == 2) ? 16'h5A5D : 16'hA5A2)) begin
            errors++;
            $display("FAIL basic_mem7: got %h", mem[33'd7]);
        end
    endtask

    task automatic test_stuck();
        sa = 33'd5; sm = 16'h0008;
        run_test(33'd0, 33'd7, 0, "stuck");
        checks++;
        if ({pass, fail_addr, fail_exp, fail_data} !== {1'b0, 33'd5, 16'hA5A0, 16'hA5A8}) begin
            errors++;
            $display("FAIL stuck_fixed: got pass=%b fa=%h fe=%h fd=%h want 0 5 a5a0 a5a8", pass, fail_addr, fail_exp, fail_data);
        end
        sm = '0;
    endtask

    task automatic test_bounds();
        run_test(33'h100000000, 33'h100000004, 0, "odd_window");
        wr_cnt = 0;
        run_test(33'h1FFFFFFFE, 33'h1FFFFFFFF, 0, "top_window");
        checks++;
        if (mem.exists(33'd0) && mem[33'd0] !== pat(33'd0, NP - 1)) begin
            errors++;
            $display("FAIL top_addr0: got %h", mem[33'd0]);
        end
        checks++;
        if (wr_cnt != 2 * NP) begin
            errors++;
            $display("FAIL top_writes: got %0d want %0d", wr_cnt, 2 * NP);
        end
        run_test(33'd20, 33'd20, 0, "single_word");
    endtask

    task automatic test_bad_cfg();
        wr_cnt = 0;
        @(negedge clk);
        cfg_base = 33'd10; cfg_last = 33'd9; start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if ({done, pass, busy, fail_addr, fail_data, fail_exp} !== {3'b100, 33'd10, 32'h0}) begin
            errors++;
            $display("FAIL bad_cfg: got done=%b pass=%b busy=%b fa=%h fd=%h fe=%h want 1 0 0 a 0 0",
                     done, pass, busy, fail_addr, fail_data, fail_exp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL bad_cfg_nowr: got writes=%0d done=%b want 0 1", wr_cnt, done);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cfg_base = 33'd0; cfg_last = 33'd7; start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        reset = 1;
        @(negedge clk);
        checks++;
        if ({wr, busy, done, pass, fail_addr, rd_addr_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got wr=%b busy=%b done=%b pass=%b fa=%h ra=%h want all 0",
                     wr, busy, done, pass, fail_addr, rd_addr_a);
        end
        reset = 0;
        run_test(33'd0, 33'd7, 0, "rerun");
    endtask

    task automatic test_back_to_back();
        run_test(33'd100, 33'd109, 1, "start_busy");
        run_test(33'd200, 33'd202, 0, "from_done");
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        int n;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 20);
            b = {1'($urandom_range(0, 1)), 32'($urandom)};
            if (b > MAXA - AW'(n - 1)) b = MAXA - AW'(n - 1);
            if ($urandom_range(0, 1) == 1) begin
                sa = b + AW'($urandom_range(0, n - 1));
                sm = 16'h1 << $urandom_range(0, 15);
            end else sm = '0;
            run_test(b, b + AW'(n - 1), 0, "random");
        end
        sm = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck();
        test_bounds();
        test_bad_cfg();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
